// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, data-enable, syncs, and a once-per-frame
// animate pulse. The strobes are registered so they always match the coordinates in the same cycle.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_animate,
    output logic [7:0]  o_frame
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
    localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);
    localparam logic [11:0] HActive  = 12'(H_ACTIVE);
    localparam logic [11:0] VActive  = 12'(V_ACTIVE);
    localparam logic [11:0] HsStart  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HsEnd    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VsStart  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VsEnd    = 12'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
        $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
    end

    logic [11:0] x_q, x_d, y_q, y_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        animate_q, animate_d;
    logic [7:0]  frame_q, frame_d;
    logic        started_q, started_d;

    logic [11:0] step_x, step_y, pos_x, pos_y;

    always_comb begin
        // Counter step; anything at or beyond the last position folds back to 0.
        if (x_q >= HLast) begin
            step_x = 12'd0;
            step_y = (y_q >= VLast) ? 12'd0 : y_q + 12'd1;
        end else begin
            step_x = x_q + 12'd1;
            step_y = (y_q > VLast) ? 12'd0 : y_q;
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        de_d      = de_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        animate_d = 1'b0;
        frame_d   = frame_q;
        started_d = started_q;
        pos_x     = x_q;
        pos_y     = y_q;

        if (i_en) begin
            // The first enabled edge after reset only validates the decode of (0,0).
            if (started_q) begin
                pos_x     = step_x;
                pos_y     = step_y;
                animate_d = (step_x == 12'd0) && (step_y == VActive);
            end
            started_d = 1'b1;
            x_d       = pos_x;
            y_d       = pos_y;
            de_d      = (pos_x < HActive) && (pos_y < VActive);
            hsync_d   = ((pos_x >= HsStart) && (pos_x < HsEnd)) ? H_POL : ~H_POL;
            vsync_d   = ((pos_y >= VsStart) && (pos_y < VsEnd)) ? V_POL : ~V_POL;
            frame_d   = frame_q + 8'(animate_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            de_q      <= 1'b0;
            hsync_q   <= ~H_POL;
            vsync_q   <= ~V_POL;
            animate_q <= 1'b0;
            frame_q   <= 8'd0;
            started_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            animate_q <= animate_d;
            frame_q   <= frame_d;
            started_q <= started_d;
        end
    end

    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_de      = de_q;
    assign o_hsync   = hsync_q;
    assign o_vsync   = vsync_q;
    assign o_animate = animate_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small raster: 16 pixels per line, 8 lines per frame.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [11:0] x, y;
    logic        de, hsync, vsync, animate;
    logic [7:0]  frame;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .o_x      (x),
        .o_y      (y),
        .o_de     (de),
        .o_hsync  (hsync),
        .o_vsync  (vsync),
        .o_animate(animate),
        .o_frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick(1'b1);
        total_cnt++;
        if ({x, y, de, hsync, vsync, animate, frame} !== {12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_state: x=%0d y=%0d de=%b hs=%b vs=%b an=%b fr=%0d, want all zero",
                     x, y, de, hsync, vsync, animate, frame);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(1'b1);
        total_cnt++;
        if (x !== 12'd0 || y !== 12'd0 || de !== 1'b1)
            $display("FAIL first_edge: x=%0d y=%0d de=%b, want 0 0 1", x, y, de);
        else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            tick(1'b1);
            total_cnt++;
            if (x !== 12'(i) || y !== 12'd0)
                $display("FAIL x_step: x=%0d y=%0d, want %0d 0", x, y, i);
            else pass_cnt++;
        end
        tick(1'b1);
        total_cnt++;
        if (x !== 12'd0 || y !== 12'd1)
            $display("FAIL line_wrap: x=%0d y=%0d, want 0 1", x, y);
        else pass_cnt++;
    endtask

    // Starts at (0,1); ends at (0,2).
    task automatic test_line;
        int de_n = 0;
        int hs_n = 0;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (x !== 12'(i) || de !== (i < 8) || hsync !== (i >= 10 && i <= 12))
                $display("FAIL line_decode: x=%0d de=%b hs=%b, want x=%0d de=%b hs=%b",
                         x, de, hsync, i, (i < 8), (i >= 10 && i <= 12));
            else pass_cnt++;
            de_n += int'(de);
            hs_n += int'(hsync);
            tick(1'b1);
        end
        total_cnt++;
        if (de_n != 8 || hs_n != 3)
            $display("FAIL line_counts: de=%0d hs=%0d, want 8 3", de_n, hs_n);
        else pass_cnt++;
    endtask

    // Starts at (0,2); covers every position once; ends at (0,2) in frame 1.
    task automatic test_frame;
        int vs_n = 0;
        int an_n = 0;
        int first_vs_x = -1;
        int first_vs_y = -1;
        int an_x = -1;
        int an_y = -1;
        int an_fr = -1;
        total_cnt++;
        if (frame !== 8'd0) $display("FAIL frame_start: frame=%0d, want 0", frame);
        else pass_cnt++;
        for (int i = 0; i < 128; i++) begin
            if (vsync) begin
                if (first_vs_x < 0) begin
                    first_vs_x = int'(x);
                    first_vs_y = int'(y);
                end
                vs_n++;
            end
            if (animate) begin
                an_n++;
                an_x = int'(x);
                an_y = int'(y);
                an_fr = int'(frame);
            end
            tick(1'b1);
        end
        total_cnt++;
        if (vs_n != 32 || first_vs_x != 0 || first_vs_y != 5)
            $display("FAIL vsync_frame: count=%0d start=(%0d,%0d), want 32 at (0,5)",
                     vs_n, first_vs_x, first_vs_y);
        else pass_cnt++;
        total_cnt++;
        if (an_n != 1 || an_x != 0 || an_y != 4 || an_fr != 1)
            $display("FAIL animate_frame: count=%0d at (%0d,%0d) frame=%0d, want 1 at (0,4) frame=1",
                     an_n, an_x, an_y, an_fr);
        else pass_cnt++;
    endtask

    // Starts at (0,2); en 1,0,0,1 across (15,3)->(0,4); ends at (1,4) in frame 2.
    task automatic test_en_toggle;
        logic [3:0] seq;
        int an_n = 0;
        repeat (31) tick(1'b1);
        total_cnt++;
        if (x !== 12'd15 || y !== 12'd3)
            $display("FAIL en_setup: x=%0d y=%0d, want 15 3", x, y);
        else pass_cnt++;
        seq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick(seq[3-i]);
            an_n += int'(animate);
            total_cnt++;
            if (x !== ((i == 3) ? 12'd1 : 12'd0) || y !== 12'd4 || frame !== 8'd2 ||
                animate !== (i == 0) || de !== 1'b0 || vsync !== 1'b0 || hsync !== 1'b0)
                $display("FAIL en_hold: step=%0d x=%0d y=%0d fr=%0d an=%b de=%b", i, x, y,
                         frame, animate, de);
            else pass_cnt++;
        end
        total_cnt++;
        if (an_n != 1) $display("FAIL en_pulse_count: got %0d, want 1", an_n);
        else pass_cnt++;
    endtask

    // 256 frames from (1,4) frame 2; comes back to the same point with the counter wrapped.
    task automatic test_wrap;
        int an_n = 0;
        bit wrap_seen = 1'b0;
        logic [7:0] prev = frame;
        for (int i = 0; i < 256 * 128; i++) begin
            tick(1'b1);
            an_n += int'(animate);
            if (prev == 8'd255 && frame == 8'd0) wrap_seen = 1'b1;
            prev = frame;
        end
        total_cnt++;
        if (an_n != 256) $display("FAIL wrap_animate: count=%0d, want 256", an_n);
        else pass_cnt++;
        total_cnt++;
        if (!wrap_seen || frame !== 8'd2 || x !== 12'd1 || y !== 12'd4)
            $display("FAIL frame_wrap: seen=%b frame=%0d at (%0d,%0d), want 1 2 (1,4)",
                     wrap_seen, frame, x, y);
        else pass_cnt++;
    endtask

    // From (1,4): reset at (9,6) with vsync active, then normal timing.
    task automatic test_reset_mid;
        repeat (40) tick(1'b1);
        total_cnt++;
        if (x !== 12'd9 || y !== 12'd6 || vsync !== 1'b1)
            $display("FAIL mid_setup: x=%0d y=%0d vs=%b, want 9 6 1", x, y, vsync);
        else pass_cnt++;
        rst_n = 1'b0;
        tick(1'b1);
        total_cnt++;
        if (x !== 12'd0 || y !== 12'd0 || frame !== 8'd0 || vsync !== 1'b0 || animate !== 1'b0 ||
            de !== 1'b0)
            $display("FAIL mid_reset: x=%0d y=%0d fr=%0d vs=%b an=%b de=%b, want all zero",
                     x, y, frame, vsync, animate, de);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(1'b1);
        tick(1'b1);
        total_cnt++;
        if (x !== 12'd1 || y !== 12'd0 || de !== 1'b1)
            $display("FAIL mid_resume: x=%0d y=%0d de=%b, want 1 0 1", x, y, de);
        else pass_cnt++;
        repeat (63) tick(1'b1);
        total_cnt++;
        if (x !== 12'd0 || y !== 12'd4 || animate !== 1'b1 || frame !== 8'd1)
            $display("FAIL mid_animate: x=%0d y=%0d an=%b fr=%0d, want 0 4 1 1", x, y, animate,
                     frame);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_en_toggle();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
